// File: rtl/hwpe_ctrl_tile_seq_pkg.sv
// Shared types and constants for the HWPE tile job sequencer.
package hwpe_ctrl_tile_seq_pkg;

  localparam int unsigned TILE_SEQ_CNT_W = 16;

  typedef enum logic [1:0] {
    TS_IDLE,
    TS_ISSUE,
    TS_DRAIN,
    TS_DONE
  } tile_seq_state_t;

  typedef struct packed {
    logic [TILE_SEQ_CNT_W-1:0] inner;
    logic [TILE_SEQ_CNT_W-1:0] outer;
    logic                      last;
  } tile_cmd_t;

endpackage

// File: rtl/hwpe_ctrl_tile_seq_cnt.sv
// Two-level (outer x inner) tile index counter with latched bounds and last-tile flag.
module hwpe_ctrl_tile_seq_cnt
  import hwpe_ctrl_tile_seq_pkg::*;
#(
  parameter int unsigned CNT_W = TILE_SEQ_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] n_inner_i,
  input  logic [CNT_W-1:0] n_outer_i,
  output logic [CNT_W-1:0] inner_o,
  output logic [CNT_W-1:0] outer_o,
  output logic             last_o
);

  logic [CNT_W-1:0] inner_max_q, outer_max_q;
  logic [CNT_W-1:0] inner_q, outer_q;
  logic             inner_wrap;

  // Bounds are stored as bound-1 so a bound of 2^CNT_W-1 never overflows the compare.
  assign inner_wrap = (inner_q == inner_max_q);
  assign last_o     = inner_wrap && (outer_q == outer_max_q);
  assign inner_o    = inner_q;
  assign outer_o    = outer_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      inner_max_q <= '0;
      outer_max_q <= '0;
      inner_q     <= '0;
      outer_q     <= '0;
    end else if (load_i) begin
      inner_max_q <= n_inner_i - CNT_W'(1);
      outer_max_q <= n_outer_i - CNT_W'(1);
      inner_q     <= '0;
      outer_q     <= '0;
    end else if (en_i) begin
      if (inner_wrap) begin
        inner_q <= '0;
        outer_q <= outer_q + CNT_W'(1);
      end else begin
        inner_q <= inner_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/hwpe_ctrl_tile_seq.sv
// Tile job sequencer: walks outer x inner tiles, bounds tiles in flight, pulses done once.
// Optional perf counters enabled by HWPE_CTRL_TILE_SEQ_PERF_EN.
//
// state    | meaning
// TS_IDLE  | waiting for start, bounds latched on accepted start
// TS_ISSUE | issuing tile commands while outstanding < MAX_OUTSTANDING
// TS_DRAIN | all tiles issued, waiting for outstanding to reach 0
// TS_DONE  | one-cycle done pulse back to the control slave
module hwpe_ctrl_tile_seq
  import hwpe_ctrl_tile_seq_pkg::*;
#(
  parameter int unsigned CNT_W           = TILE_SEQ_CNT_W,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] n_inner_i,
  input  logic [CNT_W-1:0] n_outer_i,
  output logic             tile_valid_o,
  input  logic             tile_ready_i,
  output logic [CNT_W-1:0] tile_inner_o,
  output logic [CNT_W-1:0] tile_outer_o,
  output logic             tile_last_o,
  input  logic             tile_done_i,
  output logic             busy_o,
  output logic             done_o
`ifdef HWPE_CTRL_TILE_SEQ_PERF_EN
  ,
  output logic [31:0]      perf_busy_cnt_o,
  output logic [31:0]      perf_stall_cnt_o
`endif
);

  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OUT_W-1:0] MAX_OUT = OUT_W'(MAX_OUTSTANDING);

  tile_seq_state_t  state_q, state_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic             start_acc, zero_job, hs, dec, cnt_last;

  assign start_acc    = (state_q == TS_IDLE) && start_i;
  assign zero_job     = (n_inner_i == '0) || (n_outer_i == '0);
  assign tile_valid_o = (state_q == TS_ISSUE) && (out_q < MAX_OUT);
  assign hs           = tile_valid_o && tile_ready_i;
  assign dec          = tile_done_i && (out_q != '0);
  assign tile_last_o  = (state_q == TS_ISSUE) && cnt_last;

  hwpe_ctrl_tile_seq_cnt #(
    .CNT_W (CNT_W)
  ) i_cnt (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (clear_i),
    .load_i    (start_acc),
    .en_i      (hs),
    .n_inner_i (n_inner_i),
    .n_outer_i (n_outer_i),
    .inner_o   (tile_inner_o),
    .outer_o   (tile_outer_o),
    .last_o    (cnt_last)
  );

  always_comb begin
    out_d = out_q;
    if (hs && !dec) begin
      out_d = out_q + OUT_W'(1);
    end else if (!hs && dec) begin
      out_d = out_q - OUT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    unique case (state_q)
      TS_IDLE: begin
        if (start_i) begin
          state_d = zero_job ? TS_DONE : TS_ISSUE;
        end
      end
      TS_ISSUE: begin
        busy_o = 1'b1;
        if (hs && cnt_last) begin
          state_d = TS_DRAIN;
        end
      end
      TS_DRAIN: begin
        busy_o = 1'b1;
        if (out_d == '0) begin
          state_d = TS_DONE;
        end
      end
      TS_DONE: begin
        busy_o  = 1'b1;
        done_o  = 1'b1;
        state_d = TS_IDLE;
      end
      default: state_d = TS_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_q <= TS_IDLE;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

`ifdef HWPE_CTRL_TILE_SEQ_PERF_EN
  // Saturating counters; cleared on accepted start and left untouched after done.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i || start_acc) begin
      perf_busy_cnt_o  <= '0;
      perf_stall_cnt_o <= '0;
    end else begin
      if (busy_o && (perf_busy_cnt_o != '1)) begin
        perf_busy_cnt_o <= perf_busy_cnt_o + 32'd1;
      end
      if (tile_valid_o && !tile_ready_i && (perf_stall_cnt_o != '1)) begin
        perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hwpe_ctrl_tile_seq.sv
// Self-checking bench for hwpe_ctrl_tile_seq against a tile-count reference model.
module tb_hwpe_ctrl_tile_seq;

  localparam int CNT_W = 16;
  localparam int MAXO  = 2;

  logic             clk_i = 1'b0;
  logic             rst_i, clear_i, start_i, tile_ready_i, tile_done_i;
  logic [CNT_W-1:0] n_inner_i, n_outer_i, tile_inner_o, tile_outer_o;
  logic             tile_valid_o, tile_last_o, busy_o, done_o;
`ifdef HWPE_CTRL_TILE_SEQ_PERF_EN
  logic [31:0]      perf_busy_cnt_o, perf_stall_cnt_o;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  hwpe_ctrl_tile_seq #(
    .CNT_W           (CNT_W),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .clear_i          (clear_i),
    .start_i          (start_i),
    .n_inner_i        (n_inner_i),
    .n_outer_i        (n_outer_i),
    .tile_valid_o     (tile_valid_o),
    .tile_ready_i     (tile_ready_i),
    .tile_inner_o     (tile_inner_o),
    .tile_outer_o     (tile_outer_o),
    .tile_last_o      (tile_last_o),
    .tile_done_i      (tile_done_i),
    .busy_o           (busy_o),
    .done_o           (done_o)
`ifdef HWPE_CTRL_TILE_SEQ_PERF_EN
    ,
    .perf_busy_cnt_o  (perf_busy_cnt_o),
    .perf_stall_cnt_o (perf_stall_cnt_o)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, 32'(busy_o), 0);
    check({tag, "_valid"}, 32'(tile_valid_o), 0);
    check({tag, "_done"}, 32'(done_o), 0);
  endtask

  // Job model: tile k of the job is (k % ni, k / ni), last when k == ni*no-1.
  // amode 0: run to done; 1: clear once all issued with one tile in flight; 2: clear at cycle 30.
  task automatic run_job(input int ni, input int no, input int rpct,
                         input int dmin, input int dmax, input int amode);
    longint n, issued;
    int     inflight, cyc, stalls, busyc;
    bit     done_next, finished, hs, dpulse, exp_valid;
    int     due_q[$];
    n = longint'(ni) * longint'(no);
    @(negedge clk_i);
    check("pre_busy", 32'(busy_o), 0);
    start_i      = 1'b1;
    n_inner_i    = CNT_W'(ni);
    n_outer_i    = CNT_W'(no);
    tile_ready_i = 1'b0;
    tile_done_i  = 1'b0;
    clear_i      = 1'b0;
    issued = 0; inflight = 0; cyc = 0; stalls = 0; busyc = 0;
    done_next = (n == 0);
    finished  = 1'b0;
    while (!finished) begin
      @(negedge clk_i);
      cyc++;
      busyc++;
      start_i      = ($urandom_range(0, 7) == 0);
      n_inner_i    = CNT_W'($urandom);
      n_outer_i    = CNT_W'($urandom);
      tile_ready_i = 1'b0;
      tile_done_i  = 1'b0;
      exp_valid    = (issued < n) && (inflight < MAXO);
      check("busy", 32'(busy_o), 1);
      check("done", 32'(done_o), 32'(done_next));
      check("valid", 32'(tile_valid_o), 32'(exp_valid));
      if (exp_valid && tile_valid_o) begin
        check("inner", 32'(tile_inner_o), 32'(issued % ni));
        check("outer", 32'(tile_outer_o), 32'(issued / ni));
        check("last", 32'(tile_last_o), 32'(issued == n - 1));
      end else if (issued == n) begin
        check("last_after", 32'(tile_last_o), 0);
      end
      if (done_next) begin
        finished = 1'b1;
        start_i  = 1'b0;
      end else begin
        tile_ready_i = ($urandom_range(0, 99) < rpct);
        hs = exp_valid && tile_ready_i;
        if (exp_valid && !tile_ready_i) stalls++;
        dpulse = (due_q.size() > 0) && (due_q[0] <= cyc);
        if (dpulse) begin
          void'(due_q.pop_front());
          tile_done_i = 1'b1;
        end
        if (hs) begin
          issued++;
          due_q.push_back(cyc + 1 + int'($urandom_range(dmin, dmax)));
        end
        inflight = inflight + int'(hs) - int'(dpulse);
        done_next = (issued == n) && (inflight == 0) && dpulse;
        if ((amode == 1 && issued == n && inflight == 1) || (amode == 2 && cyc == 30)) begin
          clear_i = 1'b1;
          start_i = 1'b0;
          @(negedge clk_i);
          clear_i      = 1'b0;
          tile_ready_i = 1'b0;
          tile_done_i  = 1'b0;
          check_idle("after_clear");
          check("after_clear_last", 32'(tile_last_o), 0);
          @(negedge clk_i);
          check_idle("after_clear2");
          return;
        end
        if (cyc > 3000) begin
          check("job_timeout_issued", 32'(issued), 32'(n));
          rst_i = 1'b1;
          @(negedge clk_i);
          rst_i   = 1'b0;
          start_i = 1'b0;
          return;
        end
      end
    end
    @(negedge clk_i);
    tile_ready_i = 1'b0;
    tile_done_i  = 1'b0;
    check_idle("post_done");
`ifdef HWPE_CTRL_TILE_SEQ_PERF_EN
    check("perf_busy", perf_busy_cnt_o, 32'(busyc));
    check("perf_stall", perf_stall_cnt_o, 32'(stalls));
`endif
  endtask

  task automatic idle_noise(input int k);
    repeat (k) begin
      @(negedge clk_i);
      start_i     = 1'b0;
      tile_done_i = 1'b1;
      check_idle("noise");
    end
    @(negedge clk_i);
    tile_done_i = 1'b0;
  endtask

  initial begin
    rst_i        = 1'b1;
    clear_i      = 1'b0;
    start_i      = 1'b0;
    tile_ready_i = 1'b0;
    tile_done_i  = 1'b0;
    n_inner_i    = '0;
    n_outer_i    = '0;
    repeat (2) @(negedge clk_i);
    check_idle("reset");
    check("reset_last", 32'(tile_last_o), 0);
    check("reset_inner", 32'(tile_inner_o), 0);
    check("reset_outer", 32'(tile_outer_o), 0);
`ifdef HWPE_CTRL_TILE_SEQ_PERF_EN
    check("reset_perf_busy", perf_busy_cnt_o, 0);
    check("reset_perf_stall", perf_stall_cnt_o, 0);
`endif
    rst_i = 1'b0;

    run_job(3, 2, 100, 1, 1, 0);
    run_job(3, 2, 100, 6, 6, 0);
    run_job(3, 2, 100, 0, 0, 0);
    run_job(0, 5, 100, 1, 1, 0);
    run_job(4, 0, 100, 1, 1, 0);
    run_job(0, 0, 100, 1, 1, 0);
    run_job(2, 2, 20, 0, 3, 0);
    idle_noise(3);
    run_job(2, 3, 100, 0, 2, 0);
    run_job(2, 1, 100, 3, 3, 1);
    run_job(1, 1, 100, 1, 1, 0);
    run_job(65535, 65535, 100, 0, 2, 2);
    run_job(1, 1, 50, 0, 1, 0);
    for (int j = 0; j < 12; j++) begin
      int dmin;
      dmin = int'($urandom_range(0, 2));
      run_job(int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
              int'($urandom_range(30, 100)), dmin, int'($urandom_range(dmin, 5)), 0);
      if ($urandom_range(0, 1) == 1) idle_noise(2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
